// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle main control FSM and its opcode decoder.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  // Instruction class chosen in DECODE; selects the post-decode path through the FSM.
  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ALUI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b111;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode: ALUOpcode class, next-state class and illegal flag.
module opcode_decoder
  import ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int AOPW = 3
) (
  input  logic [OPW-1:0]  opcode,
  output logic [AOPW-1:0] alu_class,
  output cls_t            next_cls,
  output logic            illegal
);

  always_comb begin
    alu_class = ALUOP_ADD;
    next_cls  = CLS_ILLEGAL;
    illegal   = 1'b1;
    case (opcode)
      OP_RTYPE: begin alu_class = ALUOP_RTYPE; next_cls = CLS_RTYPE;  illegal = 1'b0; end
      OP_LW:    begin alu_class = ALUOP_ADD;   next_cls = CLS_LOAD;   illegal = 1'b0; end
      OP_SW:    begin alu_class = ALUOP_ADD;   next_cls = CLS_STORE;  illegal = 1'b0; end
      OP_ADDI:  begin alu_class = ALUOP_ADD;   next_cls = CLS_ALUI;   illegal = 1'b0; end
      OP_BEQ:   begin alu_class = ALUOP_SUB;   next_cls = CLS_BRANCH; illegal = 1'b0; end
      OP_ANDI:  begin alu_class = ALUOP_AND;   next_cls = CLS_ALUI;   illegal = 1'b0; end
      OP_ORI:   begin alu_class = ALUOP_OR;    next_cls = CLS_ALUI;   illegal = 1'b0; end
      OP_SLTI:  begin alu_class = ALUOP_SLT;   next_cls = CLS_ALUI;   illegal = 1'b0; end
      // Jump does not use the ALU; ADD keeps ALUControl in a benign mode.
      OP_J:     begin alu_class = ALUOP_ADD;   next_cls = CLS_JUMP;   illegal = 1'b0; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback.
// Define ILLEGAL_TRAP_EN to halt on illegal opcodes (adds illegal_halt); otherwise they retire as NOPs.
module multicycle_main_control
  import ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int AOPW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic [OPW-1:0]  funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [AOPW-1:0] ALUOpcode,
  output logic [OPW-1:0]  ALUOperation,
  output logic            ir_write,
  output logic            pc_write,
  output logic            pc_branch,
  output logic            pc_jump,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            alu_src_imm,
  output logic            instr_done
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic            illegal_halt
`endif
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT    = S_HALT;
  localparam logic   ILLEGAL_RETIRES = 1'b0;
`else
  localparam state_t ILLEGAL_NEXT    = S_FETCH;
  localparam logic   ILLEGAL_RETIRES = 1'b1;
`endif

  state_t          state;
  cls_t            cls_q;
  logic [AOPW-1:0] dec_class;
  cls_t            dec_cls;
  logic            dec_illegal;

  opcode_decoder #(
    .OPW  (OPW),
    .AOPW (AOPW)
  ) u_dec (
    .opcode    (opcode),
    .alu_class (dec_class),
    .next_cls  (dec_cls),
    .illegal   (dec_illegal)
  );

  // State register plus the ALUControl inputs, which only change in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      cls_q        <= CLS_RTYPE;
      ALUOpcode    <= '0;
      ALUOperation <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          ALUOpcode    <= dec_class;
          ALUOperation <= funct;
          cls_q        <= dec_cls;
          if (dec_illegal) begin
            state <= ILLEGAL_NEXT;
          end else begin
            case (dec_cls)
              CLS_RTYPE:           state <= S_EXEC_R;
              CLS_ALUI:            state <= S_EXEC_I;
              CLS_LOAD, CLS_STORE: state <= S_MEM_ADDR;
              CLS_BRANCH:          state <= S_BRANCH;
              CLS_JUMP:            state <= S_JUMP;
              default:             state <= ILLEGAL_NEXT;
            endcase
          end
        end
        S_EXEC_R, S_EXEC_I: state <= S_WB_ALU;
        S_MEM_ADDR: state <= (cls_q == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) state <= S_WB_MEM;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Strobes decode from state; reset masks them so an in-flight access is dropped.
  always_comb begin
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_branch   = 1'b0;
    pc_jump     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_imm = 1'b0;
    instr_done  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE:   instr_done  = ILLEGAL_RETIRES & dec_illegal;
        S_EXEC_I,
        S_MEM_ADDR: alu_src_imm = 1'b1;
        S_MEM_RD:   mem_read    = 1'b1;
        S_MEM_WR: begin
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_WB_ALU: begin
          reg_write  = 1'b1;
          reg_dst    = (cls_q == CLS_RTYPE);
          instr_done = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          pc_branch  = zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_jump    = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal_halt = !rst && (state == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized bench for multicycle_main_control against an instruction-level reference model.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [2:0] ALUOpcode;
  logic [5:0] ALUOperation;
  logic ir_write, pc_write, pc_branch, pc_jump, mem_read, mem_write;
  logic reg_write, reg_dst, mem_to_reg, alu_src_imm, instr_done;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_halt;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_main_control #(.OPW(6), .AOPW(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .ALUOpcode    (ALUOpcode),
    .ALUOperation (ALUOperation),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_branch    (pc_branch),
    .pc_jump      (pc_jump),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .alu_src_imm  (alu_src_imm),
    .instr_done   (instr_done)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_halt (illegal_halt)
`endif
  );

  // Strobe vector bit positions
  localparam int B_IR = 10, B_PCW = 9, B_PCB = 8, B_PCJ = 7, B_MRD = 6, B_MWR = 5;
  localparam int B_RW = 4, B_RDST = 3, B_M2R = 2, B_IMM = 1, B_DONE = 0;

  logic [10:0] strobes;
  assign strobes = {ir_write, pc_write, pc_branch, pc_jump, mem_read, mem_write,
                    reg_write, reg_dst, mem_to_reg, alu_src_imm, instr_done};

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] cur_aop;
  logic [5:0] cur_fn;
  logic       exp_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [10:0] bv(input int n);
    return 11'(1) << n;
  endfunction

  // Reference decode table: kind 0=R 1=I-ALU 2=lw 3=sw 4=beq 5=j 6=illegal
  function automatic void classify(input logic [5:0] op, output int kind, output logic [2:0] aop);
    case (op)
      6'b000000: begin kind = 0; aop = 3'b010; end
      6'b100011: begin kind = 2; aop = 3'b000; end
      6'b101011: begin kind = 3; aop = 3'b000; end
      6'b001000: begin kind = 1; aop = 3'b000; end
      6'b000100: begin kind = 4; aop = 3'b001; end
      6'b001100: begin kind = 1; aop = 3'b011; end
      6'b001101: begin kind = 1; aop = 3'b100; end
      6'b001010: begin kind = 1; aop = 3'b111; end
      6'b000010: begin kind = 5; aop = 3'b000; end
      default:   begin kind = 6; aop = 3'b000; end
    endcase
  endfunction

  task automatic scramble();
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    zero   = 1'($urandom);
  endtask

  // One clock: drive, sample on the falling edge, advance past the next rising edge.
  task automatic step(input string tag, input logic rdy, input logic [10:0] exp);
    mem_ready = rdy;
    @(negedge clk);
    check({tag, " strobes"}, 32'(strobes), 32'(exp));
    check({tag, " aluop/funct"}, {23'b0, ALUOpcode, ALUOperation}, {23'b0, cur_aop, cur_fn});
`ifdef ILLEGAL_TRAP_EN
    check({tag, " illegal_halt"}, 32'(illegal_halt), 32'(exp_halt));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic reset_for(input int n);
    rst = 1'b1;
    scramble();
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset strobes", 32'(strobes), 32'd0);
    @(posedge clk);
    #1;
    cur_aop  = 3'b000;
    cur_fn   = 6'b0;
    exp_halt = 1'b0;
    for (int i = 1; i < n; i++) begin
      scramble();
      step("reset", 1'b1, 11'd0);
    end
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input logic z);
    int kind;
    logic [2:0] aop;
    classify(op, kind, aop);
    for (int i = 0; i < fw; i++) begin
      scramble();
      step("fetch-wait", 1'b0, bv(B_MRD));
    end
    scramble();
    step("fetch", 1'b1, bv(B_MRD) | bv(B_IR) | bv(B_PCW));
    opcode = op;
    funct  = fn;
    zero   = 1'($urandom);
    step("decode", 1'($urandom), (kind == 6 && !TRAP) ? bv(B_DONE) : 11'd0);
    cur_aop = aop;
    cur_fn  = fn;
    scramble();
    case (kind)
      0: begin
        step("exec_r", 1'($urandom), 11'd0);
        step("wb_alu_r", 1'($urandom), bv(B_RW) | bv(B_RDST) | bv(B_DONE));
      end
      1: begin
        step("exec_i", 1'($urandom), bv(B_IMM));
        step("wb_alu_i", 1'($urandom), bv(B_RW) | bv(B_DONE));
      end
      2: begin
        step("lw addr", 1'($urandom), bv(B_IMM));
        for (int i = 0; i < mw; i++) step("mem_rd-wait", 1'b0, bv(B_MRD));
        step("mem_rd", 1'b1, bv(B_MRD));
        step("wb_mem", 1'($urandom), bv(B_RW) | bv(B_M2R) | bv(B_DONE));
      end
      3: begin
        step("sw addr", 1'($urandom), bv(B_IMM));
        for (int i = 0; i < mw; i++) step("mem_wr-wait", 1'b0, bv(B_MWR));
        step("mem_wr", 1'b1, bv(B_MWR) | bv(B_DONE));
      end
      4: begin
        zero = z;
        step("branch", 1'($urandom), z ? (bv(B_PCB) | bv(B_DONE)) : bv(B_DONE));
      end
      5: step("jump", 1'($urandom), bv(B_PCJ) | bv(B_DONE));
      default: begin
        if (TRAP) begin
          exp_halt = 1'b1;
          for (int i = 0; i < 4; i++) begin
            scramble();
            step("halt", 1'b1, 11'd0);
          end
        end
      end
    endcase
  endtask

  logic [5:0] legal_ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100,
                                6'b001100, 6'b001101, 6'b001010, 6'b000010};

  initial begin
    rst = 1'b1;
    opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    cur_aop = '0; cur_fn = '0; exp_halt = 1'b0;
    @(posedge clk);
    #1;
    reset_for(2);

    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);  // R-type add
    run_instr(6'b100011, 6'b010101, 0, 2, 1'b0);  // lw, two wait cycles
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b1);  // beq taken
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b0);  // beq not taken
    run_instr(6'b001101, 6'b111000, 0, 0, 1'b0);  // ori
    run_instr(6'b001010, 6'b000111, 0, 0, 1'b0);  // slti
    run_instr(6'b101011, 6'b001100, 2, 1, 1'b0);  // sw with waits
    run_instr(6'b000010, 6'b110011, 1, 0, 1'b0);  // j
    run_instr(6'b001000, 6'b101010, 0, 0, 1'b0);  // addi
    run_instr(6'b001100, 6'b010011, 0, 0, 1'b0);  // andi

    // Reset while FETCH sees mem_ready: no IR/PC update, ALU inputs cleared.
    run_instr(6'b001101, 6'b111111, 0, 0, 1'b0);
    reset_for(2);

    // Reset during a stalled load read.
    scramble();
    step("rst-fetch", 1'b1, bv(B_MRD) | bv(B_IR) | bv(B_PCW));
    opcode = 6'b100011; funct = 6'b011011;
    step("rst-decode", 1'b1, 11'd0);
    cur_aop = 3'b000; cur_fn = 6'b011011;
    scramble();
    step("rst-addr", 1'b1, bv(B_IMM));
    step("rst-mem_rd", 1'b0, bv(B_MRD));
    reset_for(3);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      int k;
      logic [2:0] a;
      op = legal_ops[$urandom_range(0, 8)];
      if (!TRAP && $urandom_range(0, 9) == 0) begin
        do begin
          op = 6'($urandom);
          classify(op, k, a);
        end while (k != 6);
      end
      run_instr(op, 6'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                $urandom_range(0, 3), 1'($urandom));
    end

    // Illegal opcode: NOP retire, or trap until reset.
    run_instr(6'b111111, 6'b100101, 0, 0, 1'b0);
    if (TRAP) reset_for(2);
    run_instr(6'b000000, 6'b100010, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main control FSM for the processor datapath.
- Sits directly upstream of ALUControl. Decodes the instruction opcode and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives ALUOpcode[2:0] and a registered ALUOperation[5:0] (funct) into ALUControl, plus datapath strobes for PC, IR, memory and register file.
- Waits on a memory ready handshake.

Parameters:
- OPW, 6, opcode and funct field width.
- AOPW, 3, ALUOpcode width (matches ALUControl input).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- opcode  in  6  instr[31:26], valid from the IR while DECODE is active.
- funct  in  6  instr[5:0], valid while DECODE is active.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory access complete this cycle.
- ALUOpcode  out  3  operation class for ALUControl.
- ALUOperation  out  6  registered funct for ALUControl.
- ir_write  out  1  load IR.
- pc_write  out  1  PC <= PC+4.
- pc_branch  out  1  PC <= branch target.
- pc_jump  out  1  PC <= jump target.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = writeback data from memory.
- alu_src_imm  out  1  ALU B operand = sign-extended immediate.
- instr_done  out  1  one-cycle pulse on instruction retire.

Behaviour:
- Reset: state = FETCH. ALUOpcode = 3'b000. ALUOperation = 6'b0. All strobes 0. Reset mid-access abandons the access with no PC/IR update.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP. Strobes are Moore, decoded from state.
- FETCH:
  - mem_read = 1 while in FETCH.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 in the same cycle, next state DECODE.
  - When mem_ready = 0: hold in FETCH.
- DECODE:
  - ALUOperation <= funct.
  - ALUOpcode <= class code: R-type 000000 -> 010; lw 100011 / sw 101011 / addi 001000 -> 000; beq 000100 -> 001; andi 001100 -> 011; ori 001101 -> 100; slti 001010 -> 111; j 000010 -> 000 (ALU unused).
  - Next state:
    - R-type -> EXEC_R.
    - lw/sw -> MEM_ADDR.
    - addi/andi/ori/slti -> EXEC_I.
    - beq -> BRANCH.
    - j -> JUMP.
    - Any other opcode -> illegal (see optional feature).
- ALUOpcode and ALUOperation hold from DECODE until the next DECODE. ALUControl therefore sees stable inputs for the whole instruction.
- EXEC_R: alu_src_imm = 0, next WB_ALU with reg_dst = 1.
- EXEC_I: alu_src_imm = 1, next WB_ALU with reg_dst = 0.
- MEM_ADDR: alu_src_imm = 1, next MEM_RD for lw or MEM_WR for sw.
- MEM_RD: mem_read = 1; on mem_ready go to WB_MEM, else hold.
- MEM_WR: mem_write = 1; on mem_ready set instr_done = 1 and go to FETCH, else hold.
- WB_ALU / WB_MEM:
  - reg_write = 1 for one cycle.
  - mem_to_reg = 1 in WB_MEM only.
  - instr_done = 1, next FETCH.
- BRANCH: pc_branch = zero, instr_done = 1, next FETCH.
- JUMP: pc_jump = 1, instr_done = 1, next FETCH.
- Latency from FETCH entry to instr_done, with mem_ready tied to 1:
  - R-type and I-ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
- Each cycle of mem_ready = 0 adds one cycle.
- At most one of pc_write, pc_branch, pc_jump is asserted in any cycle. mem_read and mem_write are never both asserted.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE moves to state HALT, and output illegal_halt (1 bit, added port) = 1. HALT asserts no strobes and never sets instr_done. Only rst leaves HALT.
- Undefined: an illegal opcode behaves as a NOP. Next state FETCH, instr_done = 1, no reg_write or memory strobe. The illegal_halt port is absent.

Decomposition:
- Package ctrl_pkg:
  - state enum.
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI).
  - ALUOpcode class localparams (ALUOP_ADD = 000, ALUOP_SUB = 001, ALUOP_RTYPE = 010, ALUOP_AND = 011, ALUOP_OR = 100, ALUOP_SLT = 111).
- One natural sub-module: opcode_decoder. It is combinational: opcode -> {ALUOpcode class, next-state class, illegal}. The FSM and output registers remain in the top module.

Test Plan:
- Reset: rst = 1 for 2 cycles with mem_ready = 1 -> all strobes 0, ALUOpcode = 000; first cycle after release has mem_read = 1.
- R-type add: opcode 000000, funct 100000, mem_ready = 1 -> ALUOpcode = 010 and ALUOperation = 100000 from the cycle after DECODE; reg_write and reg_dst = 1 in cycle 4; instr_done in cycle 4.
- lw with 2 wait cycles in MEM_RD: opcode 100011 -> ALUOpcode = 000, mem_read held 3 cycles, then WB_MEM with mem_to_reg = 1 and reg_write = 1; total 7 cycles.
- beq: opcode 000100, zero = 1 -> ALUOpcode = 001, pc_branch = 1 in cycle 3. Repeat with zero = 0 -> pc_branch stays 0, instr_done still pulses.
- ori then slti back-to-back -> ALUOpcode 100 then 111, each held until the next DECODE; no glitch between instructions.
- Illegal opcode 111111:
  - With ILLEGAL_TRAP_EN: illegal_halt = 1, FSM stuck until rst.
  - Without: instr_done pulse and return to FETCH with no writes.
